// File: rtl/oled_spi_tx_if.sv
// Request/acknowledge link between an OLED command sequencer and the SPI byte transmitter.
// The sequencer holds spi_en high until it sees done, then drops it.
interface oled_spi_tx_if;
  logic       spi_en;
  logic [7:0] data;
  logic       dc;
  logic       done;
  logic       busy;

  modport master (
    output spi_en,
    output data,
    output dc,
    input  done,
    input  busy
  );

  modport slave (
    input  spi_en,
    input  data,
    input  dc,
    output done,
    output busy
  );
endinterface

// File: rtl/oled_spi_tx.sv
// Write-only SPI mode-3 byte transmitter for the SSD1331 (PmodOLEDrgb) serial pins.
// It sends one byte plus a D/C flag per level handshake, MSB first, and signals completion.
module oled_spi_tx #(
  parameter int unsigned CLK_DIV  = 8,
  parameter int unsigned CS_SETUP = 2,
  parameter int unsigned CS_HOLD  = 2
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  oled_spi_tx_if.slave  bus,
  output logic          cs_n_o,
  output logic          sclk_o,
  output logic          mosi_o,
  output logic          dc_o
);

  localparam int unsigned CNT_MAX_A = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
  localparam int unsigned CNT_MAX   = (CNT_MAX_A > CS_HOLD) ? CNT_MAX_A : CS_HOLD;
  localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);
  localparam int unsigned EDGES     = 16;
  localparam int unsigned EDGE_W    = $clog2(EDGES + 1);
  localparam int unsigned BYTE_W    = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_HOLD,
    S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [EDGE_W-1:0]   edge_q, edge_d;
  logic [BYTE_W-1:0]   shreg_q, shreg_d;
  logic                cs_n_q, cs_n_d;
  logic                sclk_q, sclk_d;
  logic                mosi_q, mosi_d;
  logic                dc_q, dc_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;

  // State and output registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      edge_q  <= '0;
      shreg_q <= '0;
      cs_n_q  <= 1'b1;
      sclk_q  <= 1'b1;
      mosi_q  <= 1'b0;
      dc_q    <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      edge_q  <= edge_d;
      shreg_q <= shreg_d;
      cs_n_q  <= cs_n_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      dc_q    <= dc_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state logic; one counter is reused for CS setup, SCLK half-periods and CS hold.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    edge_d  = edge_q;
    shreg_d = shreg_q;
    cs_n_d  = cs_n_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    dc_d    = dc_q;
    done_d  = done_q;
    busy_d  = busy_q;

    case (state_q)
      S_IDLE: begin
        mosi_d = 1'b0;
        if (bus.spi_en) begin
          shreg_d = bus.data;
          dc_d    = bus.dc;
          cs_n_d  = 1'b0;
          busy_d  = 1'b1;
          cnt_d   = '0;
          state_d = S_SETUP;
        end
      end

      S_SETUP: begin
        if (cnt_q == CNT_W'(CS_SETUP - 1)) begin
          // The entry into SHIFT is itself the first falling SCLK edge.
          cnt_d   = '0;
          sclk_d  = 1'b0;
          mosi_d  = shreg_q[BYTE_W-1];
          shreg_d = {shreg_q[BYTE_W-2:0], 1'b0};
          edge_d  = EDGE_W'(1);
          state_d = S_SHIFT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_SHIFT: begin
        if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
          cnt_d = '0;
          if (edge_q == EDGE_W'(EDGES)) begin
            // Final rising edge has already had its full high half-period.
            state_d = S_HOLD;
          end else begin
            sclk_d = ~sclk_q;
            edge_d = edge_q + EDGE_W'(1);
            if (sclk_q) begin
              mosi_d  = shreg_q[BYTE_W-1];
              shreg_d = {shreg_q[BYTE_W-2:0], 1'b0};
            end
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_HOLD: begin
        if (cnt_q == CNT_W'(CS_HOLD - 1)) begin
          cnt_d   = '0;
          cs_n_d  = 1'b1;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_DONE: begin
        // Leaving only on a low request prevents a held request from retriggering.
        if (!bus.spi_en) begin
          done_d  = 1'b0;
          busy_d  = 1'b0;
          mosi_d  = 1'b0;
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.done = done_q;
  assign bus.busy = busy_q;
  assign cs_n_o   = cs_n_q;
  assign sclk_o   = sclk_q;
  assign mosi_o   = mosi_q;
  assign dc_o     = dc_q;

endmodule

// File: tb/tb_oled_spi_tx.sv
// Bench for oled_spi_tx: a default-timing instance and a minimum-timing instance,
// checked against a bit-capture model and closed-form timing expectations.
module tb_oled_spi_tx;

  logic       clk;
  logic       rstn;
  logic [1:0] en;
  logic [7:0] dat [2];
  logic [1:0] dcin;
  logic [1:0] cs_n, sclk, mosi, dco, done, busy;

  int nvec;
  int nerr;

  oled_spi_tx_if bus0 ();
  oled_spi_tx_if bus1 ();

  assign bus0.spi_en = en[0];
  assign bus0.data   = dat[0];
  assign bus0.dc     = dcin[0];
  assign bus1.spi_en = en[1];
  assign bus1.data   = dat[1];
  assign bus1.dc     = dcin[1];
  assign done[0]     = bus0.done;
  assign busy[0]     = bus0.busy;
  assign done[1]     = bus1.done;
  assign busy[1]     = bus1.busy;

  oled_spi_tx u_dut0 (
    .clk_i  (clk),
    .rstn_i (rstn),
    .bus    (bus0),
    .cs_n_o (cs_n[0]),
    .sclk_o (sclk[0]),
    .mosi_o (mosi[0]),
    .dc_o   (dco[0])
  );

  oled_spi_tx #(.CLK_DIV(1), .CS_SETUP(1), .CS_HOLD(1)) u_dut1 (
    .clk_i  (clk),
    .rstn_i (rstn),
    .bus    (bus1),
    .cs_n_o (cs_n[1]),
    .sclk_o (sclk[1]),
    .mosi_o (mosi[1]),
    .dc_o   (dco[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int csu(input int u); return (u == 1) ? 1 : 2; endfunction
  function automatic int cdv(input int u); return (u == 1) ? 1 : 8; endfunction
  function automatic int chd(input int u); return (u == 1) ? 1 : 2; endfunction
  function automatic int t_exp(input int u); return csu(u) + 16 * cdv(u) + chd(u); endfunction

  // Raise the request at a falling edge and capture what the slave would sample.
  // Cycle index c=0 is the first sample after the acceptance edge.
  task automatic send(input int u, input logic [7:0] d, input logic dcv,
                      input int drop_rise, input int stop_rise,
                      output logic [7:0] got, output int nrise, output int t_done,
                      output bit tim_bad, output bit cs_bad, output bit dc_bad);
    logic prev;
    en[u]   = 1'b1;
    dat[u]  = d;
    dcin[u] = dcv;
    @(posedge clk);
    prev = 1'b1; got = '0; nrise = 0; t_done = -1;
    tim_bad = 1'b0; cs_bad = 1'b0; dc_bad = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (sclk[u] === 1'b1 && prev === 1'b0) begin
        got = {got[6:0], mosi[u]};
        if (c != csu(u) + (2 * nrise + 1) * cdv(u)) tim_bad = 1'b1;
        nrise++;
      end
      if (sclk[u] === 1'b0 && prev === 1'b1 && nrise == 0 && c != csu(u)) tim_bad = 1'b1;
      prev = sclk[u];
      if (dco[u] !== dcv) dc_bad = 1'b1;
      if (done[u] === 1'b1) begin
        t_done = c;
        if (cs_n[u] !== 1'b1 || busy[u] !== 1'b1) cs_bad = 1'b1;
        break;
      end
      if (cs_n[u] !== 1'b0 || busy[u] !== 1'b1) cs_bad = 1'b1;
      if (drop_rise != 0 && nrise >= drop_rise) begin
        en[u]   = 1'b0;
        dat[u]  = 8'hFF;
        dcin[u] = ~dcv;
      end
      if (stop_rise != 0 && nrise == stop_rise) break;
    end
  endtask

  // Drop the request after done and wait for the acknowledge to clear.
  task automatic release_req(input int u, output int hi_cnt, output bit ok);
    en[u] = 1'b0;
    hi_cnt = 0;
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (cs_n[u] === 1'b1) hi_cnt++;
      if (done[u] === 1'b0 && busy[u] === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int hc; bit ok;
    rstn = 1'b0;
    en = 2'b01; dat[0] = 8'($urandom); dcin = 2'b01; dat[1] = 8'h00;
    repeat (5) @(negedge clk);
    nvec++;
    if ({cs_n, sclk, mosi, dco, done, busy} !== 12'b11_11_00_00_00_00) begin
      nerr++;
      $display("FAIL reset_values got %b exp %b", {cs_n, sclk, mosi, dco, done, busy}, 12'b11_11_00_00_00_00);
    end
    rstn = 1'b1;
    @(negedge clk);
    nvec++;
    if (busy[0] !== 1'b1 || cs_n[0] !== 1'b0 || dco[0] !== 1'b1) begin
      nerr++;
      $display("FAIL reset_first_accept got busy=%b cs_n=%b dc=%b exp 1 0 1", busy[0], cs_n[0], dco[0]);
    end
    for (int c = 0; c < 400; c++) begin
      if (done[0] === 1'b1) break;
      @(negedge clk);
    end
    release_req(0, hc, ok);
    nvec++;
    if (!ok) begin
      nerr++;
      $display("FAIL reset_drain got ok=%0d exp 1", ok);
    end
  endtask

  task automatic test_single();
    logic [7:0] got; int nr, td, hc; bit tb_, cb, db, ok;
    send(0, 8'hA5, 1'b0, 0, 0, got, nr, td, tb_, cb, db);
    nvec++;
    if (got !== 8'hA5 || nr != 8) begin
      nerr++;
      $display("FAIL single_bits got %h/%0d exp a5/8", got, nr);
    end
    nvec++;
    if (td != t_exp(0)) begin
      nerr++;
      $display("FAIL single_done_time got %0d exp %0d", td, t_exp(0));
    end
    nvec++;
    if (tb_ || cb || db) begin
      nerr++;
      $display("FAIL single_waveform got tim=%0d cs=%0d dc=%0d exp 0 0 0", tb_, cb, db);
    end
    release_req(0, hc, ok);
    nvec++;
    if (!ok) begin
      nerr++;
      $display("FAIL single_release got %0d exp 1", ok);
    end
  endtask

  task automatic test_handshake();
    logic [7:0] seq [11];
    logic [7:0] got; int nr, td, hc; bit tb_, cb, db, ok;
    seq = '{8'h22, 8'h00, 8'h10, 8'h3C, 8'h2F, 8'h00, 8'h3F, 8'h00, 8'h00, 8'h3F, 8'h00};
    for (int i = 0; i < 11; i++) begin
      send(0, seq[i], 1'b0, 0, 0, got, nr, td, tb_, cb, db);
      nvec++;
      if (got !== seq[i] || nr != 8 || td != t_exp(0) || tb_ || cb || db) begin
        nerr++;
        $display("FAIL handshake_byte%0d got %h/%0d t=%0d exp %h/8 t=%0d", i, got, nr, td, seq[i], t_exp(0));
      end
      release_req(0, hc, ok);
      nvec++;
      if (!ok || hc + 1 < 2) begin
        nerr++;
        $display("FAIL handshake_gap%0d got cs_n high %0d ok=%0d exp >=2 ok=1", i, hc + 1, ok);
      end
    end
  endtask

  task automatic test_misuse();
    logic [7:0] got; int nr, td, hc, bad; bit tb_, cb, db, ok;
    send(0, 8'h3C, 1'b0, 2, 0, got, nr, td, tb_, cb, db);
    nvec++;
    if (got !== 8'h3C || td != t_exp(0) || tb_ || cb || db) begin
      nerr++;
      $display("FAIL misuse_drop_byte got %h t=%0d exp 3c t=%0d", got, td, t_exp(0));
    end
    @(negedge clk);
    nvec++;
    if (done[0] !== 1'b0 || busy[0] !== 1'b0) begin
      nerr++;
      $display("FAIL misuse_done_pulse got done=%b busy=%b exp 0 0", done[0], busy[0]);
    end
    send(0, 8'($urandom), 1'b0, 0, 0, got, nr, td, tb_, cb, db);
    bad = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (cs_n[0] !== 1'b1 || done[0] !== 1'b1 || sclk[0] !== 1'b1) bad++;
    end
    nvec++;
    if (bad != 0) begin
      nerr++;
      $display("FAIL misuse_retrigger got %0d bad cycles exp 0", bad);
    end
    release_req(0, hc, ok);
  endtask

  task automatic test_reset_shift();
    logic [7:0] got; int nr, td, hc; bit tb_, cb, db, ok;
    send(0, 8'hC3, 1'b1, 0, 3, got, nr, td, tb_, cb, db);
    repeat (cdv(0)) @(negedge clk);
    rstn = 1'b0;
    en[0] = 1'b0;
    #1;
    nvec++;
    if (cs_n[0] !== 1'b1 || sclk[0] !== 1'b1 || busy[0] !== 1'b0) begin
      nerr++;
      $display("FAIL reset_mid_shift got cs_n=%b sclk=%b busy=%b exp 1 1 0", cs_n[0], sclk[0], busy[0]);
    end
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    send(0, 8'h81, 1'b0, 0, 0, got, nr, td, tb_, cb, db);
    nvec++;
    if (got !== 8'h81 || nr != 8 || td != t_exp(0) || tb_ || cb || db) begin
      nerr++;
      $display("FAIL reset_after_byte got %h/%0d t=%0d exp 81/8 t=%0d", got, nr, td, t_exp(0));
    end
    release_req(0, hc, ok);
  endtask

  task automatic test_fast();
    logic [7:0] got; int nr, td, hc; bit tb_, cb, db, ok;
    send(1, 8'hFF, 1'b0, 0, 0, got, nr, td, tb_, cb, db);
    nvec++;
    if (got !== 8'hFF || td != t_exp(1) || tb_ || cb || db) begin
      nerr++;
      $display("FAIL fast_ff got %h t=%0d exp ff t=%0d", got, td, t_exp(1));
    end
    release_req(1, hc, ok);
    send(1, 8'h00, 1'b1, 0, 0, got, nr, td, tb_, cb, db);
    nvec++;
    if (got !== 8'h00 || nr != 8 || td != t_exp(1) || tb_ || cb) begin
      nerr++;
      $display("FAIL fast_00 got %h/%0d t=%0d exp 00/8 t=%0d", got, nr, td, t_exp(1));
    end
    nvec++;
    if (db || dco[1] !== 1'b1) begin
      nerr++;
      $display("FAIL fast_dc got dc_o=%b err=%0d exp 1 0", dco[1], db);
    end
    release_req(1, hc, ok);
  endtask

  task automatic test_random();
    logic [7:0] got, d; int nr, td, hc, u, dr; bit tb_, cb, db, ok, dcv;
    for (int i = 0; i < 12; i++) begin
      u   = $urandom_range(0, 1);
      d   = 8'($urandom);
      dcv = 1'($urandom);
      dr  = $urandom_range(0, 8);
      send(u, d, dcv, dr, 0, got, nr, td, tb_, cb, db);
      nvec++;
      if (got !== d || nr != 8 || td != t_exp(u) || tb_ || cb || db) begin
        nerr++;
        $display("FAIL random%0d u%0d got %h/%0d t=%0d exp %h/8 t=%0d", i, u, got, nr, td, d, t_exp(u));
      end
      release_req(u, hc, ok);
      nvec++;
      if (!ok || dco[u] !== dcv || mosi[u] !== 1'b0) begin
        nerr++;
        $display("FAIL random%0d_idle got ok=%0d dc=%b mosi=%b exp 1 %b 0", i, ok, dco[u], mosi[u], dcv);
      end
    end
  endtask

  initial begin
    nvec = 0;
    nerr = 0;
    rstn = 1'b0;
    en = 2'b00;
    dcin = 2'b00;
    dat[0] = 8'h00;
    dat[1] = 8'h00;
    @(negedge clk);
    test_reset();
    test_single();
    test_handshake();
    test_misuse();
    test_reset_shift();
    test_fast();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
